// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states,
// Booth digit encoding, window recode and iteration count.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} digit_t;

  function automatic int iter_of(input int width);
    return width / 2 + 1;
  endfunction

  function automatic digit_t recode(input logic [2:0] win);
    digit_t d;
    case (win)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_seq_if.sv
// Start/done handshake and operand/result bus of the Booth multiplier.
interface booth_r4_seq_if #(parameter int WIDTH = 224);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] c;

  modport master (output start, sgn, a, b, input ready, busy, done, c);
  modport slave  (input start, sgn, a, b, output ready, busy, done, c);
endinterface

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth window decode: 3-bit multiplier window to adder controls.
module booth_r4_recode
  import booth_pkg::*;
(
  input  logic [2:0] win,
  output logic       neg,
  output logic       two,
  output logic       zero
);

  digit_t digit;

  always_comb begin
    digit = recode(win);
    neg   = (digit == M1) || (digit == M2);
    two   = (digit == P2) || (digit == M2);
    zero  = (digit == ZERO);
  end

endmodule

// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth multiplier: two multiplier bits retired per cycle,
// signed or unsigned operands selected per operation.
module booth_r4_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 224
) (
  input  logic           clk,
  input  logic           rst,
  booth_r4_seq_if.slave  bus
);

  localparam int ITER = iter_of(WIDTH);
  localparam int XW   = WIDTH + 2;
  localparam int AW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER + 1);

  state_t          state, state_nxt;
  logic            accept;
  logic [XW-1:0]   a_ext;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   q;
  logic [CW-1:0]   cnt;
  logic [XW-1:0]   a_in_ext, b_in_ext;
  logic            neg, two, zero;
  logic [AW-1:0]   addend, sum;

  assign a_in_ext = {{2{bus.sgn & bus.a[WIDTH-1]}}, bus.a};
  assign b_in_ext = {{2{bus.sgn & bus.b[WIDTH-1]}}, bus.b};

  booth_r4_recode u_recode (
    .win  (q[2:0]),
    .neg  (neg),
    .two  (two),
    .zero (zero)
  );

  // Subtraction folds into the add as one's complement plus carry-in.
  always_comb begin
    addend = '0;
    if (!zero) addend = two ? {a_ext, 1'b0} : {a_ext[XW-1], a_ext};
    sum = acc + (addend ^ {AW{neg}}) + AW'(neg);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (cnt == CW'(1)) state_nxt = DONE;
      DONE: begin
        accept    = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ready = (state == IDLE) || (state == DONE);
  assign bus.busy  = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      a_ext    <= '0;
      acc      <= '0;
      q        <= '0;
      cnt      <= '0;
      bus.done <= 1'b0;
      bus.c    <= '0;
    end else begin
      state    <= state_nxt;
      bus.done <= (state == DONE);
      // After ITER shifts the product sits in {acc, q[AW-1:1]}; q[0] is stale.
      if (state == DONE) bus.c <= {acc[WIDTH-3:0], q[AW-1:1]};
      if (accept) begin
        a_ext <= a_in_ext;
        acc   <= '0;
        q     <= {b_in_ext, 1'b0};
        cnt   <= CW'(ITER);
      end else if (state == RUN) begin
        acc <= {{2{sum[AW-1]}}, sum[AW-1:2]};
        q   <= {sum[1:0], q[AW-1:2]};
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_seq.sv
// Self-checking bench for booth_r4_seq at WIDTH=8 (vectors, corner sequences,
// random sweep) plus a random sweep at WIDTH=224.
module tb_booth_r4_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  booth_r4_seq_if #(.WIDTH(8))   if8 ();
  booth_r4_seq_if #(.WIDTH(224)) if224 ();

  booth_r4_seq #(.WIDTH(8))   u_dut8   (.clk(clk), .rst(rst), .bus(if8));
  booth_r4_seq #(.WIDTH(224)) u_dut224 (.clk(clk), .rst(rst), .bus(if224));

  typedef struct {
    bit          sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] model8(input bit s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  function automatic logic [447:0] model224(input bit s, input logic [223:0] a, input logic [223:0] b);
    logic [447:0] ea, eb;
    ea = s ? {{224{a[223]}}, a} : {224'h0, a};
    eb = s ? {{224{b[223]}}, b} : {224'h0, b};
    return ea * eb;
  endfunction

  task automatic chk(input string nm, input logic [447:0] act, input logic [447:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] res, output int lat);
    @(negedge clk);
    if8.sgn = s; if8.a = a; if8.b = b; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    if8.a = ~a; if8.b = ~b; if8.sgn = ~s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if8.done && lat < 30);
    res = if8.c;
  endtask

  task automatic run_op224(input bit s, input logic [223:0] a, input logic [223:0] b,
                           output logic [447:0] res, output int lat);
    @(negedge clk);
    if224.sgn = s; if224.a = a; if224.b = b; if224.start = 1'b1;
    @(negedge clk);
    if224.start = 1'b0;
    if224.a = '0; if224.b = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if224.done && lat < 300);
    res = if224.c;
  endtask

  initial begin
    logic [15:0]  r8;
    logic [447:0] r224;
    logic [223:0] ra, rb;
    logic [15:0]  expq[$];
    int           lat, nd, t, last_t;
    bit           s;

    if8.start = 1'b0; if8.sgn = 1'b0; if8.a = '0; if8.b = '0;
    if224.start = 1'b0; if224.sgn = 1'b0; if224.a = '0; if224.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_c", if8.c, 0);
    chk("reset_ready", if8.ready, 1);
    chk("reset_busy", if8.busy, 0);
    chk("reset_done", if8.done, 0);
    rst = 1'b1;

    vecs.push_back('{1'b1, 8'h80, 8'h80, 16'h4000});
    vecs.push_back('{1'b0, 8'hFF, 8'hFF, 16'hFE01});
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 16'h0001});
    vecs.push_back('{1'b1, 8'h07, 8'hFD, 16'hFFEB});
    vecs.push_back('{1'b0, 8'h00, 8'h5A, 16'h0000});
    vecs.push_back('{1'b1, 8'h00, 8'hA5, 16'h0000});
    vecs.push_back('{1'b0, 8'h80, 8'h80, 16'h4000});
    vecs.push_back('{1'b1, 8'h7F, 8'h80, 16'hC080});
    vecs.push_back('{1'b0, 8'h7F, 8'h80, 16'h3F80});
    vecs.push_back('{1'b1, 8'h01, 8'hFF, 16'hFFFF});
    vecs.push_back('{1'b0, 8'h01, 8'hFF, 16'h00FF});
    foreach (vecs[i]) begin
      run_op8(vecs[i].sgn, vecs[i].a, vecs[i].b, r8, lat);
      chk($sformatf("vec%0d_c", i), r8, vecs[i].c);
      chk($sformatf("vec%0d_latency", i), lat, 6);
    end

    // Start while busy is ignored.
    @(negedge clk);
    if8.sgn = 1'b0; if8.a = 8'd5; if8.b = 8'd9; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    chk("busy_ready_low", if8.ready, 0);
    chk("busy_busy_high", if8.busy, 1);
    @(negedge clk);
    if8.a = 8'd3; if8.b = 8'd3; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    chk("busy_ready_low2", if8.ready, 0);
    nd = 0;
    r8 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.done) begin nd++; r8 = if8.c; end
    end
    chk("busy_done_count", nd, 1);
    chk("busy_c", r8, 16'd45);

    // Back-to-back with start held high.
    t = 0; last_t = -1;
    @(negedge clk);
    if8.sgn = 1'($urandom); if8.a = 8'($urandom); if8.b = 8'($urandom); if8.start = 1'b1;
    if (if8.ready) expq.push_back(model8(if8.sgn, if8.a, if8.b));
    for (int i = 0; i < 40 || expq.size() > 0; i++) begin
      @(negedge clk);
      t++;
      if (if8.done) begin
        chk("b2b_c", if8.c, (expq.size() > 0) ? expq.pop_front() : ~if8.c);
        if (last_t >= 0) chk("b2b_gap", t - last_t, 6);
        last_t = t;
      end
      if (i >= 40) if8.start = 1'b0;
      else begin
        if8.sgn = 1'($urandom); if8.a = 8'($urandom); if8.b = 8'($urandom);
      end
      if (if8.ready && if8.start) expq.push_back(model8(if8.sgn, if8.a, if8.b));
      if (i > 100) begin
        chk("b2b_drain_timeout", expq.size(), 0);
        break;
      end
    end
    if8.start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during RUN abandons the operation.
    if8.sgn = 1'b0; if8.a = 8'd9; if8.b = 8'd11; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_c", if8.c, 0);
    chk("rst_busy", if8.busy, 0);
    chk("rst_ready", if8.ready, 1);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if8.done) nd++;
    end
    chk("rst_no_done", nd, 0);
    run_op8(1'b1, 8'hF3, 8'h0B, r8, lat);
    chk("rst_next_c", r8, model8(1'b1, 8'hF3, 8'h0B));
    chk("rst_next_latency", lat, 6);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom);
      ra[7:0] = 8'($urandom);
      rb[7:0] = 8'($urandom);
      run_op8(s, ra[7:0], rb[7:0], r8, lat);
      chk("rand8_c", r8, model8(s, ra[7:0], rb[7:0]));
      chk("rand8_latency", lat, 6);
    end

    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom);
      for (int k = 0; k < 7; k++) begin
        ra[k*32 +: 32] = $urandom;
        rb[k*32 +: 32] = $urandom;
      end
      if (i == 0) begin ra = {1'b1, 223'h0}; rb = {1'b1, 223'h0}; end
      if (i == 1) begin ra = '1; rb = '1; end
      run_op224(s, ra, rb, r224, lat);
      chk("rand224_c", r224, model224(s, ra, rb));
      chk("rand224_latency", lat, 114);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
